// File: rtl/client_rx_s_if.sv
// Packet receive port (aggregate side) plus the AXI-Stream byte output of client_rx_s.
// slave is the block's view; master is the view of whoever drives packets and consumes the stream.
interface client_rx_s_if;
  logic       rx_ready;
  logic       rx_strobe;
  logic       rx_crc;
  logic [7:0] packet_in;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic       m_tlast;

  modport slave (
    input  rx_ready, rx_strobe, rx_crc, packet_in, m_tready,
    output m_tdata, m_tvalid, m_tlast
  );

  modport master (
    output rx_ready, rx_strobe, rx_crc, packet_in, m_tready,
    input  m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/client_rx_s.sv
// Store-and-forward packet receiver: buffers a packet and commits it on good CRC.
// Rolls the packet back on a bad CRC or an overflow, then streams committed packets out as AXI-Stream bytes.
module client_rx_s #(
  parameter int AW       = 11,
  parameter int JUMBO_DW = 14,
  parameter int LD       = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  client_rx_s_if.slave bus,
  output logic [15:0]  pkt_cnt,
  output logic [15:0]  drop_crc_cnt,
  output logic [15:0]  drop_ovf_cnt
);

  localparam logic [AW:0]         DEPTH   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]         P_ONE   = 1;
  localparam logic [LD:0]         LDEPTH  = {1'b1, {LD{1'b0}}};
  localparam logic [LD:0]         LF_ONE  = 1;
  localparam logic [JUMBO_DW-1:0] LEN_ONE = 1;
  localparam logic [JUMBO_DW-1:0] LEN_MAX = '1;
  localparam logic [15:0]         C_ONE   = 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM} state_t;

  logic [7:0]          r_ram   [2**AW];
  logic [JUMBO_DW-1:0] r_lfifo [2**LD];

  logic [AW:0]         r_wr_ptr, r_commit_ptr, r_rd_ptr;
  logic [LD:0]         r_lf_wp, r_lf_rp;
  logic [JUMBO_DW-1:0] r_len, r_rem;
  logic                r_drop, r_rx_prev, r_in_pkt;
  logic [15:0]         r_pkt_cnt, r_crc_cnt, r_ovf_cnt;
  state_t              r_state;
  logic [7:0]          r_tdata;
  logic                r_tvalid, r_tlast;

  logic                w_sop, w_eop, w_strobe, w_buf_full, w_ovf, w_wr_en, w_commit;
  logic                w_lf_full, w_lf_empty, w_xfer, w_drop_base;
  logic [LD:0]         w_lf_cnt;
  logic [AW:0]         w_wr_base, w_rd_next;
  logic [JUMBO_DW-1:0] w_len_base, w_lf_head;

  // r_rx_prev resets high so a packet already in flight at reset release never looks like a start.
  assign w_sop       = bus.rx_ready & ~r_rx_prev;
  assign w_eop       = ~bus.rx_ready & r_in_pkt;
  assign w_lf_cnt    = r_lf_wp - r_lf_rp;
  assign w_lf_full   = (w_lf_cnt == LDEPTH);
  assign w_lf_empty  = (w_lf_cnt == '0);
  assign w_lf_head   = r_lfifo[r_lf_rp[LD-1:0]];

  // The start cycle can already carry a byte, so it works from the restarted packet state.
  assign w_wr_base   = w_sop ? r_commit_ptr : r_wr_ptr;
  assign w_len_base  = w_sop ? '0 : r_len;
  assign w_drop_base = w_sop ? w_lf_full : r_drop;
  assign w_strobe    = bus.rx_strobe & bus.rx_ready & (w_sop | r_in_pkt);
  assign w_buf_full  = ((w_wr_base - r_rd_ptr) == DEPTH);
  assign w_ovf       = w_strobe & ~w_drop_base & (w_buf_full | (w_len_base == LEN_MAX));
  assign w_wr_en     = w_strobe & ~w_drop_base & ~w_ovf;
  assign w_commit    = w_eop & ~r_drop & bus.rx_crc & (r_len != '0);

  assign w_xfer      = r_tvalid & bus.m_tready;
  assign w_rd_next   = r_rd_ptr + P_ONE;

  always_ff @(posedge clk) begin
    if (w_wr_en)  r_ram[w_wr_base[AW-1:0]] <= bus.packet_in;
    if (w_commit) r_lfifo[r_lf_wp[LD-1:0]] <= r_len;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_prev    <= 1'b1;
      r_in_pkt     <= 1'b0;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_len        <= '0;
      r_drop       <= 1'b0;
      r_lf_wp      <= '0;
      r_pkt_cnt    <= '0;
      r_crc_cnt    <= '0;
      r_ovf_cnt    <= '0;
    end else begin
      r_rx_prev <= bus.rx_ready;
      if (w_sop)      r_in_pkt <= 1'b1;
      else if (w_eop) r_in_pkt <= 1'b0;

      if (w_eop) begin
        if (w_commit) begin
          r_commit_ptr <= r_wr_ptr;
          r_lf_wp      <= r_lf_wp + LF_ONE;
          r_pkt_cnt    <= r_pkt_cnt + C_ONE;
        end else begin
          r_wr_ptr <= r_commit_ptr;
          if (r_drop)           r_ovf_cnt <= r_ovf_cnt + C_ONE;
          else if (!bus.rx_crc) r_crc_cnt <= r_crc_cnt + C_ONE;
        end
      end else if (w_sop | r_in_pkt) begin
        r_wr_ptr <= w_wr_en ? w_wr_base + P_ONE : w_wr_base;
        r_len    <= w_wr_en ? w_len_base + LEN_ONE : w_len_base;
        r_drop   <= w_drop_base | w_ovf;
      end
    end
  end

  // Output holds the byte at r_rd_ptr; the next byte is fetched on the same edge it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rd_ptr <= '0;
      r_lf_rp  <= '0;
      r_rem    <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (!w_lf_empty) r_state <= S_LOAD;
        S_LOAD: begin
          r_tdata  <= r_ram[r_rd_ptr[AW-1:0]];
          r_tvalid <= 1'b1;
          r_tlast  <= (w_lf_head == LEN_ONE);
          r_rem    <= w_lf_head - LEN_ONE;
          r_state  <= S_STREAM;
        end
        S_STREAM: if (w_xfer) begin
          r_rd_ptr <= w_rd_next;
          if (r_tlast) begin
            r_lf_rp  <= r_lf_rp + LF_ONE;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_state  <= (w_lf_cnt > LF_ONE) ? S_LOAD : S_IDLE;
          end else begin
            r_tdata <= r_ram[w_rd_next[AW-1:0]];
            r_tlast <= (r_rem == LEN_ONE);
            r_rem   <= r_rem - LEN_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.m_tdata  = r_tdata;
  assign bus.m_tvalid = r_tvalid;
  assign bus.m_tlast  = r_tlast;
  assign pkt_cnt      = r_pkt_cnt;
  assign drop_crc_cnt = r_crc_cnt;
  assign drop_ovf_cnt = r_ovf_cnt;

endmodule

// File: tb/tb_client_rx_s.sv
// Directed and randomized-ready bench for client_rx_s with a 64-byte buffer and 4-entry length FIFO.
module tb_client_rx_s;
  localparam int AW = 6, JDW = 14, LD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pkt_cnt, drop_crc_cnt, drop_ovf_cnt;
  client_rx_s_if bus();

  client_rx_s #(.AW(AW), .JUMBO_DW(JDW), .LD(LD)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .pkt_cnt(pkt_cnt), .drop_crc_cnt(drop_crc_cnt), .drop_ovf_cnt(drop_ovf_cnt)
  );

  int         errors = 0, checks = 0, unstable = 0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  bit         rnd_ready = 0, fix_ready = 0, prev_stall = 0;
  logic [8:0] prev_beat = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    bus.m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : fix_ready;
  end

  // Transfers are recorded half a cycle before the edge that completes them.
  always @(negedge clk) begin
    if (!rst_n) prev_stall = 0;
    else begin
      if (prev_stall && (bus.m_tvalid !== 1'b1 || {bus.m_tlast, bus.m_tdata} !== prev_beat))
        unstable++;
      if (bus.m_tvalid && bus.m_tready) got_q.push_back({bus.m_tlast, bus.m_tdata});
      prev_stall = bus.m_tvalid && !bus.m_tready;
      prev_beat  = {bus.m_tlast, bus.m_tdata};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0; rnd_ready = 0; fix_ready = 0;
    bus.rx_ready = 0; bus.rx_strobe = 0; bus.rx_crc = 0; bus.packet_in = 0;
    repeat (3) cyc();
    rst_n = 1;
    cyc();
    got_q.delete();
  endtask

  task automatic send_pkt(input int len, input bit crc, input logic [7:0] seed, input bit rnd);
    logic [7:0] d;
    bus.rx_ready = 1;
    if (len == 0) cyc();
    for (int i = 0; i < len; i++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin bus.rx_strobe = 0; cyc(); end
      d = rnd ? 8'($urandom) : seed + 8'(i);
      bus.rx_strobe = 1; bus.packet_in = d;
      cyc();
      if (rnd) exp_q.push_back({1'(i == len - 1), d});
    end
    bus.rx_strobe = 0; bus.rx_ready = 0; bus.rx_crc = crc;
    cyc();
    bus.rx_crc = 0;
  endtask

  task automatic wait_got(input int n);
    for (int k = 0; k < 3000 && got_q.size() < n; k++) cyc();
  endtask

  task automatic test_reset();
    rst_n = 0;
    bus.rx_ready = 0; bus.rx_strobe = 0; bus.rx_crc = 0; bus.packet_in = 0;
    #2;
    checks++; if (bus.m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", bus.m_tvalid); end
    checks++; if (bus.m_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b expected 0", bus.m_tlast); end
    checks++; if (bus.m_tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata: got %h expected 00", bus.m_tdata); end
    checks++;
    if ({pkt_cnt, drop_crc_cnt, drop_ovf_cnt} !== 48'h0) begin
      errors++; $display("FAIL reset_counters: got %h expected 0", {pkt_cnt, drop_crc_cnt, drop_ovf_cnt});
    end
    repeat (3) cyc();
    rst_n = 1;
    repeat (4) cyc();
    checks++; if (bus.m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_idle_tvalid: got %b expected 0", bus.m_tvalid); end
  endtask

  task automatic test_good_64();
    int n, bad;
    do_reset();
    fix_ready = 1;
    cyc();
    send_pkt(64, 1, 8'h10, 0);
    n = 1;
    while (bus.m_tvalid !== 1'b1 && n < 10) begin cyc(); n++; end
    checks++; if (n > 3) begin errors++; $display("FAIL good64_latency: got %0d edges expected <= 3", n); end
    wait_got(64);
    repeat (5) cyc();
    checks++; if (got_q.size() != 64) begin errors++; $display("FAIL good64_count: got %0d expected 64", got_q.size()); end
    bad = 0;
    for (int i = 0; i < 64 && i < got_q.size(); i++)
      if (got_q[i] !== {1'(i == 63), 8'(8'h10 + i)}) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL good64_data: got %0d bad beats expected 0", bad); end
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL good64_pkt_cnt: got %0d expected 1", pkt_cnt); end
    checks++; if (bus.m_tvalid !== 1'b0) begin errors++; $display("FAIL good64_idle: got %b expected 0", bus.m_tvalid); end
  endtask

  task automatic test_crc_drop();
    int bad;
    do_reset();
    fix_ready = 1;
    send_pkt(64, 0, 8'h00, 0);
    // strobes while rx_ready is low must not create data
    bus.rx_strobe = 1; bus.packet_in = 8'hEE;
    cyc(); cyc();
    bus.rx_strobe = 0;
    send_pkt(0, 1, 8'h00, 0);
    send_pkt(10, 1, 8'hA0, 0);
    wait_got(10);
    repeat (20) cyc();
    checks++; if (got_q.size() != 10) begin errors++; $display("FAIL crc_count: got %0d expected 10", got_q.size()); end
    bad = 0;
    for (int i = 0; i < 10 && i < got_q.size(); i++)
      if (got_q[i] !== {1'(i == 9), 8'(8'hA0 + i)}) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL crc_data: got %0d bad beats expected 0", bad); end
    checks++; if (drop_crc_cnt !== 16'd1) begin errors++; $display("FAIL crc_drop_cnt: got %0d expected 1", drop_crc_cnt); end
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL crc_pkt_cnt: got %0d expected 1", pkt_cnt); end
    checks++; if (drop_ovf_cnt !== 16'd0) begin errors++; $display("FAIL crc_ovf_cnt: got %0d expected 0", drop_ovf_cnt); end
  endtask

  task automatic test_overflow();
    int bad;
    do_reset();
    send_pkt(40, 1, 8'h20, 0);
    send_pkt(40, 1, 8'h60, 0);
    repeat (5) cyc();
    checks++; if (drop_ovf_cnt !== 16'd1) begin errors++; $display("FAIL ovf_cnt: got %0d expected 1", drop_ovf_cnt); end
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL ovf_pkt_cnt: got %0d expected 1", pkt_cnt); end
    checks++; if (bus.m_tvalid !== 1'b1 || got_q.size() != 0) begin
      errors++; $display("FAIL ovf_stalled: got tvalid=%b beats=%0d expected tvalid=1 beats=0", bus.m_tvalid, got_q.size());
    end
    fix_ready = 1;
    wait_got(40);
    repeat (10) cyc();
    checks++; if (got_q.size() != 40) begin errors++; $display("FAIL ovf_count: got %0d expected 40", got_q.size()); end
    bad = 0;
    for (int i = 0; i < 40 && i < got_q.size(); i++)
      if (got_q[i] !== {1'(i == 39), 8'(8'h20 + i)}) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL ovf_data: got %0d bad beats expected 0", bad); end
  endtask

  task automatic test_lfifo_full();
    int bad;
    do_reset();
    for (int k = 0; k < 5; k++) send_pkt(8, 1, 8'(k * 16), 0);
    repeat (3) cyc();
    checks++; if (drop_ovf_cnt !== 16'd1) begin errors++; $display("FAIL lfifo_ovf_cnt: got %0d expected 1", drop_ovf_cnt); end
    checks++; if (pkt_cnt !== 16'd4) begin errors++; $display("FAIL lfifo_pkt_cnt: got %0d expected 4", pkt_cnt); end
    fix_ready = 1;
    wait_got(32);
    repeat (10) cyc();
    checks++; if (got_q.size() != 32) begin errors++; $display("FAIL lfifo_count: got %0d expected 32", got_q.size()); end
    bad = 0;
    for (int i = 0; i < 32 && i < got_q.size(); i++)
      if (got_q[i] !== {1'(i % 8 == 7), 8'((i / 8) * 16 + i % 8)}) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL lfifo_data: got %0d bad beats expected 0", bad); end
  endtask

  task automatic test_back_to_back();
    int scan = 0, lasts = 0, sent_bytes = 0, sent_pkts = 0, len, w, bad, base_unst, nlast;
    do_reset();
    exp_q.delete();
    base_unst = unstable;
    rnd_ready = 1;
    for (int p = 0; p < 200; p++) begin
      len = $urandom_range(1, 48);
      w = 0;
      forever begin
        while (scan < got_q.size()) begin
          if (got_q[scan][8]) lasts++;
          scan++;
        end
        if (sent_bytes - got_q.size() + len <= 64 && sent_pkts - lasts <= 3) break;
        if (w++ > 2000) break;
        cyc();
      end
      send_pkt(len, 1, 8'h00, 1);
      sent_bytes += len;
      sent_pkts++;
    end
    wait_got(exp_q.size());
    repeat (10) cyc();
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    bad = 0; nlast = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      if (got_q[i][8]) nlast++;
      if (i >= exp_q.size() || got_q[i] !== exp_q[i]) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_data: got %0d bad beats expected 0", bad); end
    checks++; if (nlast != 200) begin errors++; $display("FAIL b2b_tlast: got %0d expected 200", nlast); end
    checks++; if (unstable != base_unst) begin errors++; $display("FAIL b2b_stable: got %0d violations expected 0", unstable - base_unst); end
    checks++; if (pkt_cnt !== 16'd200) begin errors++; $display("FAIL b2b_pkt_cnt: got %0d expected 200", pkt_cnt); end
    checks++; if ((drop_ovf_cnt | drop_crc_cnt) !== 16'd0) begin
      errors++; $display("FAIL b2b_drops: got ovf=%0d crc=%0d expected 0", drop_ovf_cnt, drop_crc_cnt);
    end
    rnd_ready = 0;
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    send_pkt(20, 1, 8'h40, 0);
    repeat (3) cyc();
    bus.rx_ready = 1;
    for (int i = 0; i < 10; i++) begin bus.rx_strobe = 1; bus.packet_in = 8'(8'h90 + i); cyc(); end
    rst_n = 0;
    #1;
    checks++; if (bus.m_tvalid !== 1'b0 || bus.m_tdata !== 8'h00) begin
      errors++; $display("FAIL mid_async: got tvalid=%b tdata=%h expected 0/00", bus.m_tvalid, bus.m_tdata);
    end
    checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL mid_async_cnt: got %0d expected 0", pkt_cnt); end
    repeat (3) cyc();
    checks++; if ({bus.m_tvalid, bus.m_tlast, bus.m_tdata} !== 10'h0) begin
      errors++; $display("FAIL mid_during: got %h expected 0", {bus.m_tvalid, bus.m_tlast, bus.m_tdata});
    end
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin bus.rx_strobe = 1; bus.packet_in = 8'(8'hB0 + i); cyc(); end
    bus.rx_strobe = 0; bus.rx_ready = 0; bus.rx_crc = 1;
    cyc();
    bus.rx_crc = 0;
    fix_ready = 1;
    repeat (10) cyc();
    checks++; if (got_q.size() != 0 || bus.m_tvalid !== 1'b0) begin
      errors++; $display("FAIL mid_after: got beats=%0d tvalid=%b expected 0/0", got_q.size(), bus.m_tvalid);
    end
    checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL mid_tail_cnt: got %0d expected 0", pkt_cnt); end
    send_pkt(6, 1, 8'h70, 0);
    wait_got(6);
    repeat (5) cyc();
    bad = 0;
    for (int i = 0; i < 6 && i < got_q.size(); i++)
      if (got_q[i] !== {1'(i == 5), 8'(8'h70 + i)}) bad++;
    checks++; if (got_q.size() != 6 || bad != 0) begin
      errors++; $display("FAIL mid_next: got beats=%0d bad=%0d expected 6/0", got_q.size(), bad);
    end
    checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL mid_next_cnt: got %0d expected 1", pkt_cnt); end
  endtask

  initial begin
    test_reset();
    test_good_64();
    test_crc_drop();
    test_overflow();
    test_lfifo_full();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
